imem_program_loader: RTL
========================

Name: imem_program_loader

Overview:
Producer side of the instruction path: accepts decoded I-type field tuples (op, rs, rt, imm) over a valid/ready stream and encodes each tuple into a 32-bit instruction word. It buffers the words in a small FIFO and writes them sequentially into instruction memory. The CPU core is held in its not-run state until the program is fully written, then released. It sits between the test/host interface and the imem write port, ahead of fetch and the instruction decoder.

Parameters:
ADDR_W, 8, imem word-address width; program capacity 2**ADDR_W words
FIFO_DEPTH, 4, encoded-word buffer depth; power of two, >=2
BASE_ADDR, 0, first imem word address written per session

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  pulse; begins a load session (ignored while busy)
fld_valid  in  1  field tuple valid
fld_ready  out  1  field tuple accepted when valid&ready
fld_op  in  6  opcode
fld_rs  in  5  source register
fld_rt  in  5  target register
fld_imm  in  16  immediate
fld_last  in  1  marks final tuple of program
imem_we  out  1  imem write strobe
imem_addr  out  ADDR_W  imem word address
imem_wdata  out  32  encoded instruction
cpu_run  out  1  high = core may fetch/execute
busy  out  1  session in progress
err_overflow  out  1  sticky; program exceeded capacity
word_count  out  ADDR_W+1  words written this session

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-low on rst_n, sampled on the rising edge.
- Reset: state=IDLE; FIFO empty; all outputs 0 (fld_ready, imem_we, imem_addr, imem_wdata, cpu_run, busy, err_overflow, word_count).
- Encoding, pure bit placement with no arithmetic: word = {op[31:26], rs[25:21], rt[20:16], imm[15:0]}. The op field position matches the decoder's I_OP slice.
- States: IDLE, LOAD, DRAIN, DONE, ERR.
- IDLE: start -> LOAD; write pointer <= BASE_ADDR, word_count <= 0, err_overflow <= 0, cpu_run <= 0.
- LOAD: fld_ready = !fifo_full. A handshake pushes the encoded word. A handshake with fld_last=1 -> DRAIN (fld_ready low from the next cycle).
- DRAIN: fld_ready=0; continue popping until FIFO empty -> DONE.
- DONE: cpu_run=1, busy=0. start -> LOAD (cpu_run drops the same edge, and the counters and pointers are reinitialised as in IDLE).
- busy = state is LOAD or DRAIN.
- Write side, in LOAD and DRAIN: when FIFO not empty, pop one word per cycle. imem_we=1 with imem_addr=current pointer and imem_wdata=popped word, all registered outputs. The pointer and word_count increment after each write.
- Latency: a tuple accepted at edge N appears on imem_we/imem_wdata in the cycle after edge N+1. Back-to-back tuples give one write per cycle.
- FIFO: push and pop in the same cycle is allowed when not full and not empty. When full, fld_ready=0 even if a pop occurs that cycle (no pass-through).
- Empty FIFO in LOAD: imem_we=0, and the state is held waiting for tuples.
- Overflow: if a pop is pending while word_count == 2**ADDR_W, the write is suppressed. err_overflow <= 1 (sticky), state -> ERR. The pointer never wraps onto earlier words.
- ERR: fld_ready=0, cpu_run=0, busy=0, FIFO flushed. Only start (-> LOAD, clears err) or reset exits.
- fld_last on the first tuple is legal (one-word program).
- start while busy is ignored.
- Reset mid-session: immediate return to reset values; partial imem contents are not rolled back.
- The fld_* inputs are sampled only on the handshake; changing them while fld_ready=0 has no effect.

Decomposition:
- Shared defines, alongside the existing I_OP / OP_* macros: field slice macros I_RS, I_RT, I_IMM; a state encoding for the loader FSM; and an INST_W=32 constant.
- One sub-module: sync_fifo (WIDTH=32, DEPTH=FIFO_DEPTH, synchronous active-low reset, full/empty flags). It is reusable elsewhere in the design.
- The encoder is an inline concatenation, not a separate module.

Test Plan:
- Reset, start, then one tuple op=6'b001000, rs=0, rt=9, imm=5, last=1 -> a single imem write of addr 0, data 0x20090005, two cycles after the handshake. Then cpu_run=1, word_count=1, busy=0.
- 4 tuples back-to-back with valid held high (imm=1..4, last on the 4th) -> writes on 4 consecutive cycles to addrs 0..3, data 0x20090001..0x20090004. fld_ready never drops, and DONE follows the 4th write.
- Valid held high while imem draining is stalled by FIFO_DEPTH=4 filling under bursty input: force full -> fld_ready=0 for exactly the full cycles. No tuple is lost or duplicated, and the order is preserved.
- ADDR_W=2 with 5 tuples -> 4 writes (addrs 0..3). The 5th write is suppressed, err_overflow=1, cpu_run=0. A subsequent start clears err and reloads from addr 0.
- rst_n=0 asserted mid-burst after 2 writes -> next edge: all outputs 0 and state IDLE. start is then required before any further writes.
- start pulsed during LOAD is ignored. A second start in DONE drops cpu_run on the same edge and restarts at BASE_ADDR with word_count=0.

Source files
------------

// File: rtl/imem_program_loader_pkg.sv
// Shared definitions for the instruction-memory program loader.
// Contents:
//   INST_W        - instruction word width
//   I_*_HI/_LO    - I-type field bit positions (op/rs/rt/imm), matching the decoder slices
//   OP_ADDI       - example opcode used by host-side stimulus
//   loader_state_e - loader FSM state encoding
package imem_program_loader_pkg;

    localparam int unsigned INST_W = 32;

    // I-type field slices; op position must track the decoder's I_OP slice.
    localparam int unsigned I_OP_HI  = 31;
    localparam int unsigned I_OP_LO  = 26;
    localparam int unsigned I_RS_HI  = 25;
    localparam int unsigned I_RS_LO  = 21;
    localparam int unsigned I_RT_HI  = 20;
    localparam int unsigned I_RT_LO  = 16;
    localparam int unsigned I_IMM_HI = 15;
    localparam int unsigned I_IMM_LO = 0;

    localparam logic [5:0] OP_ADDI = 6'b001000;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StDrain,
        StDone,
        StErr
    } loader_state_e;

endpackage

// File: rtl/imem_program_loader_if.sv
// Field-tuple stream plus imem write port of the program loader.
//   fld_valid/fld_ready      - tuple handshake (host -> loader)
//   fld_op/rs/rt/imm/last    - I-type fields and end-of-program marker
//   imem_we/addr/wdata       - registered imem write port (loader -> memory)
// modport master: host/memory side; modport slave: loader side.
interface imem_program_loader_if #(
    parameter int unsigned ADDR_W = 8
);
    import imem_program_loader_pkg::*;

    logic              fld_valid;
    logic              fld_ready;
    logic [5:0]        fld_op;
    logic [4:0]        fld_rs;
    logic [4:0]        fld_rt;
    logic [15:0]       fld_imm;
    logic              fld_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [INST_W-1:0] imem_wdata;

    modport master (
        output fld_valid, fld_op, fld_rs, fld_rt, fld_imm, fld_last,
        input  fld_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  fld_valid, fld_op, fld_rs, fld_rt, fld_imm, fld_last,
        output fld_ready, imem_we, imem_addr, imem_wdata
    );

endinterface

// File: rtl/imem_program_loader_sync_fifo.sv
// Synchronous FIFO with full/empty flags and a flush input.
//   clk_i, rst_ni  - clock, synchronous active-low reset
//   flush_i        - discard all entries (wins over push/pop)
//   push_i/wdata_i - write; ignored when full
//   pop_i/rdata_o  - read; rdata_o shows the head entry, pop ignored when empty
//   full_o/empty_o - occupancy flags
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module imem_program_loader_sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (PtrW + 1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/imem_program_loader.sv
// Encodes I-type field tuples into instruction words, buffers them and writes them
// sequentially into instruction memory, holding the core in reset-like not-run state
// until the whole program is written.
//   clk, rst_n    - clock, synchronous active-low reset
//   start         - pulse; begins a load session (ignored while busy)
//   bus (slave)   - tuple stream in, imem write port out
//   cpu_run       - core may fetch/execute (program complete)
//   busy          - session in progress (LOAD or DRAIN)
//   err_overflow  - sticky; program exceeded 2**ADDR_W words
//   word_count    - words written this session
module imem_program_loader
    import imem_program_loader_pkg::*;
#(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    imem_program_loader_if.slave      bus,
    output logic                      cpu_run,
    output logic                      busy,
    output logic                      err_overflow,
    output logic [ADDR_W:0]           word_count
);

    localparam logic [ADDR_W:0]   Capacity = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);

    loader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [INST_W-1:0] wdata_q, wdata_d;

    logic              fifo_push, fifo_pop, fifo_flush;
    logic              fifo_full, fifo_empty;
    logic [INST_W-1:0] fifo_rdata;
    logic [INST_W-1:0] enc_word;
    logic              fld_ready;
    logic              writing;

    assign enc_word = {bus.fld_op, bus.fld_rs, bus.fld_rt, bus.fld_imm};

    imem_program_loader_sync_fifo #(
        .WIDTH (INST_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (fifo_flush),
        .push_i  (fifo_push),
        .wdata_i (enc_word),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        err_d      = err_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;

        // No pass-through when full: ready depends only on registered occupancy.
        fld_ready = (state_q == StLoad) && !fifo_full;
        fifo_push = bus.fld_valid && fld_ready;
        writing   = (state_q == StLoad) || (state_q == StDrain);

        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d  = StLoad;
                    wr_ptr_d = BaseAddr;
                    count_d  = '0;
                    err_d    = 1'b0;
                end
            end
            StLoad: begin
                if (fifo_push && bus.fld_last) state_d = StDrain;
            end
            StDrain: begin
                if (fifo_empty) state_d = StDone;
            end
            default: state_d = StIdle;
        endcase

        // Write side: one pop per cycle; a full program suppresses the write and aborts.
        if (writing && !fifo_empty) begin
            if (count_q == Capacity) begin
                err_d      = 1'b1;
                state_d    = StErr;
                fifo_flush = 1'b1;
            end else begin
                fifo_pop = 1'b1;
                we_d     = 1'b1;
                addr_d   = wr_ptr_q;
                wdata_d  = fifo_rdata;
                wr_ptr_d = wr_ptr_q + 1'b1;
                count_d  = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign bus.fld_ready  = fld_ready;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign cpu_run        = (state_q == StDone);
    assign busy           = (state_q == StLoad) || (state_q == StDrain);
    assign err_overflow   = err_q;
    assign word_count     = count_q;

endmodule
